// File: rtl/spi_cmd_responder_pkg.sv
// spi_cmd_responder_pkg: opcodes, FSM state encoding and default response bytes
package spi_cmd_responder_pkg;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ = 8'h02;
  localparam logic [7:0] STATUS_OK_DEF = 8'h00;
  localparam logic [7:0] STATUS_ERR_DEF = 8'hEE;
  localparam logic [7:0] BAD_OPCODE_DEF = 8'hEF;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WBUS, S_RBUS, S_RSEND, S_STATUS, S_BADOP
  } state_t;
  function automatic logic op_known(input logic [7:0] op);
    return op == OP_NOP || op == OP_WRITE || op == OP_READ;
  endfunction
endpackage

// File: rtl/spi_cmd_responder_if.sv
// spi_cmd_responder_if: RX/TX byte streams and register bus of the command responder
interface spi_cmd_responder_if #(parameter int ADDR_BYTES = 2);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [8*ADDR_BYTES-1:0] bus_addr;
  logic [7:0] bus_wdata;
  logic bus_we;
  logic bus_re;
  logic [7:0] bus_rdata;
  logic bus_ack;
  modport slave (
    input in_data, in_valid, out_ready, bus_rdata, bus_ack,
    output in_ready, out_data, out_valid, bus_addr, bus_wdata, bus_we, bus_re
  );
  modport master (
    output in_data, in_valid, out_ready, bus_rdata, bus_ack,
    input in_ready, out_data, out_valid, bus_addr, bus_wdata, bus_we, bus_re
  );
endinterface

// File: rtl/spi_cmd_responder_bus_timeout_ctr.sv
// bus_timeout_ctr: counts strobe cycles without ack, expire fires on the TIMEOUT-th one (0 disables)
module bus_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic expire
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt;
  assign expire = (TIMEOUT != 0) && start && !ack && cnt == W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (start && !ack && !expire) ? cnt + W'(1) : '0;
endmodule

// File: rtl/spi_cmd_responder.sv
// spi_cmd_responder: parses write/read packets from the RX stream, runs them on an 8-bit
// register bus and returns status/read bytes on the TX stream
module spi_cmd_responder
  import spi_cmd_responder_pkg::*;
#(
  parameter int ADDR_BYTES = 2,
  parameter int TIMEOUT = 255,
  parameter logic [7:0] STATUS_OK = STATUS_OK_DEF,
  parameter logic [7:0] STATUS_ERR = STATUS_ERR_DEF,
  parameter logic [7:0] BAD_OPCODE_RESP = BAD_OPCODE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic abort,
  spi_cmd_responder_if.slave io,
  output logic busy,
  output logic err
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int AB_W = ADDR_BYTES > 1 ? $clog2(ADDR_BYTES) : 1;
  state_t state, state_n;
  logic [AW-1:0] addr;
  logic [7:0] wdata, cnt, cnt_dec, out_data_q;
  logic [AB_W-1:0] abyte;
  logic out_valid_q, is_wr, tout, expire, acc, tx, done, last;
  assign acc = io.in_valid && io.in_ready;
  assign tx = out_valid_q && io.out_ready;
  assign done = io.bus_ack || expire;
  // len 0 wraps through 256 transfers because cnt is 8 bits
  assign cnt_dec = cnt - 8'd1;
  assign last = cnt_dec == 8'd0;
  assign io.in_ready = (state == S_IDLE && !out_valid_q) || state == S_ADDR || state == S_LEN || state == S_WDATA;
  assign io.bus_we = state == S_WBUS;
  assign io.bus_re = state == S_RBUS;
  assign io.bus_addr = addr;
  assign io.bus_wdata = wdata;
  assign io.out_data = out_data_q;
  assign io.out_valid = out_valid_q;
  assign busy = state != S_IDLE || out_valid_q;
  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk),
    .rst_n(rst_n),
    .start((io.bus_we || io.bus_re) && !abort),
    .ack(io.bus_ack),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (acc) state_n = !op_known(io.in_data) ? S_BADOP : io.in_data == OP_NOP ? S_IDLE : S_ADDR;
      S_ADDR: if (acc && abyte == AB_W'(ADDR_BYTES - 1)) state_n = S_LEN;
      S_LEN: if (acc) state_n = is_wr ? S_WDATA : S_RBUS;
      S_WDATA: if (acc) state_n = S_WBUS;
      S_WBUS: if (done) state_n = last ? S_STATUS : S_WDATA;
      S_RBUS: if (done) state_n = S_RSEND;
      S_RSEND: if (tx) state_n = last ? S_IDLE : S_RBUS;
      S_STATUS, S_BADOP: if (tx) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      wdata <= '0;
      cnt <= '0;
      abyte <= '0;
      is_wr <= 1'b0;
      tout <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      err <= 1'b0;
    end else if (abort) begin
      addr <= '0;
      cnt <= '0;
      abyte <= '0;
      tout <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (acc) begin
          is_wr <= io.in_data == OP_WRITE;
          abyte <= '0;
          tout <= 1'b0;
          if (!op_known(io.in_data)) begin
            out_valid_q <= 1'b1;
            out_data_q <= BAD_OPCODE_RESP;
            err <= 1'b1;
          end
        end
        S_ADDR: if (acc) begin
          addr <= AW'({addr, io.in_data});
          abyte <= abyte + AB_W'(1);
        end
        S_LEN: if (acc) cnt <= io.in_data;
        S_WDATA: if (acc) wdata <= io.in_data;
        S_WBUS: if (done) begin
          addr <= addr + AW'(1);
          cnt <= cnt_dec;
          tout <= tout || expire;
          if (expire) err <= 1'b1;
          if (last) begin
            out_valid_q <= 1'b1;
            out_data_q <= (tout || expire) ? STATUS_ERR : STATUS_OK;
          end
        end
        S_RBUS: if (done) begin
          out_valid_q <= 1'b1;
          out_data_q <= io.bus_ack ? io.bus_rdata : 8'hFF;
          if (expire) err <= 1'b1;
        end
        S_RSEND: if (tx) begin
          out_valid_q <= 1'b0;
          addr <= addr + AW'(1);
          cnt <= cnt_dec;
        end
        S_STATUS, S_BADOP: if (tx) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_spi_cmd_responder.sv
// tb_spi_cmd_responder: directed packet sequences against a small register-bus responder model
module tb_spi_cmd_responder;
  logic clk, rst_n, abort, busy, err;
  int total, passed, fails;
  int ack_dly, hi, we_cycles, re_cycles, rd_pulses;
  logic ack_en, late_ack, re_q;
  logic [15:0] wr_addr[$];
  logic [7:0] wr_data[$];
  logic [7:0] rxq[$];

  spi_cmd_responder_if #(.ADDR_BYTES(2)) io();

  spi_cmd_responder #(.ADDR_BYTES(2), .TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .abort(abort),
    .io(io.slave),
    .busy(busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign io.bus_rdata = io.bus_addr[7:0];

  // bus slave: acks after ack_dly strobe cycles, logs writes and read strobes
  always @(posedge clk) begin
    #1;
    hi = (io.bus_we || io.bus_re) ? hi + 1 : 0;
    if (io.bus_we) we_cycles++;
    if (io.bus_re) re_cycles++;
    if (io.bus_re && !re_q) rd_pulses++;
    re_q = io.bus_re;
    io.bus_ack = late_ack || (ack_en && (io.bus_we || io.bus_re) && hi == ack_dly + 1);
    if (io.bus_ack && io.bus_we) begin
      wr_addr.push_back(io.bus_addr);
      wr_data.push_back(io.bus_wdata);
    end
  end

  always @(negedge clk) if (io.out_valid && io.out_ready) rxq.push_back(io.out_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    io.in_data = b;
    io.in_valid = 1'b1;
    @(negedge clk);
    while (!io.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!io.in_ready) chk("in_ready_timeout", io.in_ready, 1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < max);
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_out_valid(input int max);
    int n;
    n = 0;
    while (!io.out_valid && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!io.out_valid) chk("out_valid_timeout", io.out_valid, 1);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  initial begin
    int n, bad;
    total = 0; passed = 0; fails = 0;
    ack_dly = 1; ack_en = 1'b1; late_ack = 1'b0; re_q = 1'b0; hi = 0;
    we_cycles = 0; re_cycles = 0; rd_pulses = 0;
    rst_n = 1'b0; abort = 1'b0;
    io.in_data = 8'h00; io.in_valid = 1'b0; io.out_ready = 1'b1; io.bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_strobes", {io.bus_we, io.bus_re}, 0);
    chk("rst_busy_err", {busy, err}, 0);
    chk("rst_addr", io.bus_addr, 16'h0000);
    chk("rst_out_data", io.out_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // two-byte write at 0x0010
    send_pkt(8'h01, 8'h00, 8'h10, 8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    wait_idle(100);
    chk("wr_count", wr_addr.size(), 2);
    chk("wr0_addr", wr_addr[0], 16'h0010);
    chk("wr0_data", wr_data[0], 8'hAA);
    chk("wr1_addr", wr_addr[1], 16'h0011);
    chk("wr1_data", wr_data[1], 8'hBB);
    chk("wr_resp_count", rxq.size(), 1);
    chk("wr_resp", rxq[0], 8'h00);
    chk("wr_err", err, 0);

    // three-byte read at 0x1234 with a 5-cycle stall after the first byte
    rxq.delete(); rd_pulses = 0;
    send_pkt(8'h02, 8'h12, 8'h34, 8'h03);
    n = 0;
    while (rxq.size() < 1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    io.out_ready = 1'b0;
    wait_out_valid(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd_stall_valid", io.out_valid, 1);
      chk("rd_stall_data", io.out_data, 8'h35);
    end
    chk("rd_stall_no_extra", rd_pulses, 2);
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    wait_idle(100);
    chk("rd_count", rxq.size(), 3);
    chk("rd_bytes", {rxq[0], rxq[1], rxq[2]}, 24'h343536);
    chk("rd_pulses", rd_pulses, 3);

    // len 0 from 0xFFFF: 256 reads wrapping through 0x0000
    rxq.delete(); rd_pulses = 0;
    send_pkt(8'h02, 8'hFF, 8'hFF, 8'h00);
    wait_idle(3000);
    chk("wrap_count", rxq.size(), 256);
    chk("wrap_pulses", rd_pulses, 256);
    chk("wrap_first", rxq[0], 8'hFF);
    chk("wrap_second", rxq[1], 8'h00);
    chk("wrap_last", rxq[255], 8'hFE);
    bad = 0;
    for (int i = 1; i < 256; i++) if (rxq[i] !== 8'(i - 1)) bad++;
    chk("wrap_seq", bad, 0);
    chk("wrap_end_addr", io.bus_addr, 16'h00FF);

    // timeouts with no ack
    rxq.delete(); ack_en = 1'b0; we_cycles = 0; re_cycles = 0;
    send_pkt(8'h01, 8'h00, 8'h05, 8'h01);
    send_byte(8'h77);
    wait_idle(100);
    chk("to_we_cycles", we_cycles, 4);
    chk("to_resp", rxq[0], 8'hEE);
    chk("to_err", err, 1);
    chk("to_no_write", wr_addr.size(), 2);
    send_pkt(8'h02, 8'h00, 8'h05, 8'h01);
    wait_idle(100);
    chk("to_re_cycles", re_cycles, 4);
    chk("to_rd_count", rxq.size(), 2);
    chk("to_rd_resp", rxq[1], 8'hFF);
    ack_en = 1'b1;

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_clears_err", err, 0);

    // NOP then bad opcode, then a normal read
    rxq.delete();
    send_byte(8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("nop_silent", rxq.size(), 0);
    chk("nop_state", {busy, err}, 0);
    send_byte(8'h5A);
    wait_idle(50);
    chk("bad_count", rxq.size(), 1);
    chk("bad_resp", rxq[0], 8'hEF);
    chk("bad_err", err, 1);
    send_pkt(8'h02, 8'h00, 8'h42, 8'h01);
    wait_idle(100);
    chk("after_bad_rd", rxq[1], 8'h42);

    // abort while a write strobe is held, then a stray ack
    rxq.delete(); ack_en = 1'b0;
    send_pkt(8'h01, 8'h00, 8'h20, 8'h01);
    send_byte(8'h55);
    chk("abort_wbus_pre", io.bus_we, 1);
    pulse_abort();
    chk("abort_wbus_strobes", {io.bus_we, io.bus_re}, 0);
    chk("abort_wbus_idle", {busy, io.out_valid, io.in_ready}, 3'b001);
    chk("abort_keeps_err", err, 1);
    late_ack = 1'b1;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("late_ack_ignored", {busy, 8'(rxq.size()), 8'(wr_addr.size())}, {1'b0, 8'd0, 8'd2});
    ack_en = 1'b1;

    // abort while a read byte is pending
    io.out_ready = 1'b0;
    send_pkt(8'h02, 8'h00, 8'h30, 8'h02);
    wait_out_valid(50);
    chk("abort_rsend_pre", io.out_data, 8'h30);
    pulse_abort();
    chk("abort_rsend_state", {busy, io.out_valid, io.bus_re}, 0);
    io.out_ready = 1'b1;
    rd_pulses = 0;
    send_pkt(8'h02, 8'h00, 8'h00, 8'h01);
    wait_idle(100);
    chk("post_abort_count", rxq.size(), 1);
    chk("post_abort_data", rxq[0], 8'h00);
    chk("post_abort_pulses", rd_pulses, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
